// File: rtl/sync_lutram_fifo_1w_2r_pkg.sv
// Shared helpers for the 1-write / 2-read LUTRAM FIFO.
//   log2x    : ceiling log2, gives the pointer width for a given depth
//   is_pow2  : depth legality check used by the simulation assertion
//   re_e     : encoding of the thermometer-coded dequeue request
package sync_lutram_fifo_1w_2r_pkg;

    typedef enum logic [1:0] {
        RE_NONE    = 2'b00,
        RE_ONE     = 2'b01,
        RE_ILLEGAL = 2'b10,
        RE_TWO     = 2'b11
    } re_e;

    function automatic int log2x(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_lutram_fifo_1w_2r_if.sv
// Bus bundle for the 1-write / 2-read FIFO.
//   din/we   : enqueue data and request (producer -> FIFO)
//   re       : thermometer-coded dequeue request (consumer -> FIFO)
//   dout0/1  : the two oldest entries, valid per avail bits
//   avail    : [0] at least one entry, [1] at least two entries
//   empty/full/count : registered occupancy status
interface sync_lutram_fifo_1w_2r_if
    import sync_lutram_fifo_1w_2r_pkg::*;
#(
    parameter int DWIDTH = 1,
    parameter int DEPTH  = 64
);
    localparam int CW = log2x(DEPTH) + 1;

    logic [DWIDTH-1:0] din;
    logic              we;
    logic [1:0]        re;
    logic [DWIDTH-1:0] dout0;
    logic [DWIDTH-1:0] dout1;
    logic [1:0]        avail;
    logic              empty;
    logic              full;
    logic [CW-1:0]     count;

    modport master (
        output din, we, re,
        input  dout0, dout1, avail, empty, full, count
    );

    modport slave (
        input  din, we, re,
        output dout0, dout1, avail, empty, full, count
    );

endinterface

// File: rtl/sync_lutram_fifo_1w_2r_lutram.sv
// LUTRAM storage: one synchronous write port, two asynchronous read ports.
//   clk        : write clock
//   we_i       : write enable
//   waddr_i    : write address
//   wdata_i    : write data
//   raddr0_i/1 : read addresses
//   rdata0_o/1 : combinational read data
// Contents are intentionally not reset so the array maps onto distributed RAM.
module lutram_1w2r
    import sync_lutram_fifo_1w_2r_pkg::*;
#(
    parameter int DWIDTH = 1,
    parameter int DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [log2x(DEPTH)-1:0]  waddr_i,
    input  logic [DWIDTH-1:0]        wdata_i,
    input  logic [log2x(DEPTH)-1:0]  raddr0_i,
    input  logic [log2x(DEPTH)-1:0]  raddr1_i,
    output logic [DWIDTH-1:0]        rdata0_o,
    output logic [DWIDTH-1:0]        rdata1_o
);

    (* syn_ramstyle = "select_ram" *)
    logic [DWIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/sync_lutram_fifo_1w_2r.sv
// Single-clock FIFO: one enqueue per cycle, up to two in-order dequeues.
//   clk : clock
//   rst : synchronous, active-high reset
//   bus : slave side of sync_lutram_fifo_1w_2r_if
//         (din/we enqueue, re dequeue, dout0/dout1 oldest pair,
//          avail/empty/full/count registered status)
// Status flags are registered from next-count, so no combinational path
// exists from we/re to any flag. Read data is combinational from head, and
// a write is never bypassed to the read ports in the same cycle.
module sync_lutram_fifo_1w_2r
    import sync_lutram_fifo_1w_2r_pkg::*;
#(
    parameter int DWIDTH = 1,
    parameter int DEPTH  = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    sync_lutram_fifo_1w_2r_if.slave   bus
);

    localparam int PW = log2x(DEPTH);
    localparam int CW = PW + 1;

    (* syn_maxfan = 16 *) logic [PW-1:0] head_q;
    (* syn_maxfan = 16 *) logic [PW-1:0] tail_q;
    logic [PW-1:0] head_d;
    logic [PW-1:0] tail_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          empty_q, empty_d;
    logic          full_q,  full_d;
    logic [1:0]    avail_q, avail_d;

    logic          we_e;
    logic          rd0;
    logic          rd1;
    logic [1:0]    n_rd;

    // rd1 requires rd0's request bit too, so the illegal 10 code dequeues
    // nothing, and 11 with a single entry degrades to a single dequeue.
    always_comb begin
        we_e    = bus.we & ~full_q;
        rd0     = bus.re[0] & avail_q[0];
        rd1     = bus.re[1] & bus.re[0] & avail_q[1];
        n_rd    = {1'b0, rd0} + {1'b0, rd1};
        head_d  = head_q + PW'(n_rd);
        tail_d  = tail_q + PW'(we_e);
        count_d = count_q + CW'(we_e) - CW'(n_rd);
        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
        avail_d = {(count_d >= CW'(2)), (count_d >= CW'(1))};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            avail_q <= 2'b00;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            avail_q <= avail_d;
        end
    end

    lutram_1w2r #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk      (clk),
        .we_i     (we_e),
        .waddr_i  (tail_q),
        .wdata_i  (bus.din),
        .raddr0_i (head_q),
        .raddr1_i (head_q + PW'(1)),
        .rdata0_o (bus.dout0),
        .rdata1_o (bus.dout1)
    );

    assign bus.count = count_q;
    assign bus.empty = empty_q;
    assign bus.full  = full_q;
    assign bus.avail = avail_q;

`ifndef SYNTHESIS
    // Request misuse is reported but tolerated; the gating above already
    // makes every such request harmless.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (is_pow2(DEPTH) && DEPTH >= 4)
                else $error("DEPTH must be a power of two and at least 4");
            assert (!(bus.we && full_q))
                else $warning("enqueue while full, write dropped");
            assert (!(bus.re[0] && empty_q))
                else $warning("dequeue while empty, request dropped");
            assert (!(bus.re == RE_TWO && !avail_q[1]))
                else $warning("double dequeue with fewer than two entries");
            assert (bus.re != RE_ILLEGAL)
                else $warning("dequeue code 10 is illegal, nothing dequeued");
        end
    end
`endif

endmodule
